// File: rtl/det_session_arbiter_if.sv
// ---------------------------------------------------------------------------
// det_session_arbiter_if
//   Bundles the requester-side and detector-side signals of the shared
//   pattern-detector session arbiter.
//
//   REQ     [N]      per-requester session request (level)
//   BIT_IN  [N]      per-requester serial data bit
//   GNT     [N]      one-hot grant to the current session owner
//   DET_RST          registered clear to the shared detector
//   DET_IN           serial bit routed to the detector
//   DET_OUT          detector output (registered inside the detector)
//   HIT_CNT [CNT_W]  hit count of the last completed session
//   DONE             one-cycle session-complete pulse
//   DONE_ID [ID_W]   index of the requester whose session completed
//
//   slave  : arbiter side      master : requester/detector side
// ---------------------------------------------------------------------------
interface det_session_arbiter_if #(
    parameter int N           = 4,
    parameter int SESSION_LEN = 8,
    parameter int ID_W        = $clog2(N),
    parameter int CNT_W       = $clog2(SESSION_LEN + 1)
);
    logic [N-1:0]     REQ;
    logic [N-1:0]     BIT_IN;
    logic [N-1:0]     GNT;
    logic             DET_RST;
    logic             DET_IN;
    logic             DET_OUT;
    logic [CNT_W-1:0] HIT_CNT;
    logic             DONE;
    logic [ID_W-1:0]  DONE_ID;

    modport slave (
        input  REQ, BIT_IN, DET_OUT,
        output GNT, DET_RST, DET_IN, HIT_CNT, DONE, DONE_ID
    );

    modport master (
        output REQ, BIT_IN, DET_OUT,
        input  GNT, DET_RST, DET_IN, HIT_CNT, DONE, DONE_ID
    );
endinterface

// File: rtl/det_session_arbiter.sv
// ---------------------------------------------------------------------------
// det_session_arbiter
//   Time-shares one serial pattern detector between N requesters. A
//   round-robin arbiter picks an owner in IDLE, the detector is cleared for
//   one cycle, SESSION_LEN bits of the owner's BIT_IN are streamed into it,
//   and the number of cycles the detector reported a hit is published with
//   a one-cycle DONE pulse and the owner's index.
//
//   CLK   clock, rising edge
//   RST   asynchronous, active-high reset
//   bus   det_session_arbiter_if.slave (REQ, BIT_IN, DET_OUT in;
//         GNT, DET_RST, DET_IN, HIT_CNT, DONE, DONE_ID out)
// ---------------------------------------------------------------------------
module det_session_arbiter #(
    parameter int N           = 4,
    parameter int SESSION_LEN = 8,
    parameter int ID_W        = $clog2(N),
    parameter int CNT_W       = $clog2(SESSION_LEN + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    det_session_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(SESSION_LEN);
    localparam logic [ID_W:0]    NL       = (ID_W + 1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SESSION_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_REPORT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [ID_W-1:0]  r_owner, r_ptr, r_done_id;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt, r_hit_cnt;
    logic             r_det_rst, r_done;

    logic [2*N-1:0]   w_req2;
    logic [N-1:0]     w_rot;
    logic [ID_W-1:0]  w_off, w_pick;
    logic [ID_W:0]    w_sum;
    logic [N-1:0]     w_gnt;
    logic             w_det_in;

    // Round robin: rotate REQ so the pointer lands on bit 0, take the lowest
    // set bit, then rotate the offset back into a requester index.
    assign w_req2 = {bus.REQ, bus.REQ} >> r_ptr;
    assign w_rot  = w_req2[N-1:0];

    always_comb begin
        w_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = ID_W'(j);
        end
    end

    assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_pick = (w_sum >= NL) ? ID_W'(w_sum - NL) : w_sum[ID_W-1:0];

    // Next state and combinational outputs
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_det_in    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|bus.REQ) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_gnt[r_owner] = 1'b1;
                w_state_nxt    = S_RUN;
            end
            S_RUN: begin
                w_gnt[r_owner] = 1'b1;
                w_det_in       = bus.BIT_IN[r_owner];
                if (r_idx == LAST_IDX) w_state_nxt = S_FLUSH;
            end
            S_FLUSH:  w_state_nxt = S_REPORT;
            S_REPORT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_hit_cnt <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_det_rst <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            // Registered so the detector clear is glitch-free and lines up
            // exactly with the CLEAR cycle.
            r_det_rst <= (w_state_nxt == S_CLEAR);
            r_done    <= (w_state_nxt == S_REPORT);
            case (r_state)
                S_IDLE: begin
                    if (|bus.REQ) r_owner <= w_pick;
                end
                S_CLEAR: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
                S_RUN: begin
                    r_idx <= r_idx + 1'b1;
                    // DET_OUT in RUN cycle 0 still reflects the cleared
                    // detector, so sampling starts one cycle in.
                    if (r_idx != '0) r_cnt <= r_cnt + CNT_W'(bus.DET_OUT);
                end
                S_FLUSH: begin
                    // Last sample (response to the final bit) folded in while
                    // loading the result so it is visible alongside DONE.
                    r_hit_cnt <= r_cnt + CNT_W'(bus.DET_OUT);
                    r_done_id <= r_owner;
                end
                S_REPORT: begin
                    r_ptr <= (r_owner == LAST_ID) ? '0 : r_owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.GNT     = w_gnt;
    assign bus.DET_RST = r_det_rst;
    assign bus.DET_IN  = w_det_in;
    assign bus.HIT_CNT = r_hit_cnt;
    assign bus.DONE    = r_done;
    assign bus.DONE_ID = r_done_id;
endmodule

// File: tb/tb_det_session_arbiter.sv
// ---------------------------------------------------------------------------
// tb_det_session_arbiter
//   Directed bench for det_session_arbiter (N=4, SESSION_LEN=8). A small
//   "11" pattern detector (registered output, async clear on DET_RST) stands
//   in for the shared detector; a stub mode forces DET_OUT=1.
// ---------------------------------------------------------------------------
module tb_det_session_arbiter;
    logic CLK;
    logic RST;
    logic stub;
    logic det_prev, det_q;
    int   n_chk  = 0;
    int   n_pass = 0;

    det_session_arbiter_if #(.N(4), .SESSION_LEN(8)) bus ();

    det_session_arbiter #(.N(4), .SESSION_LEN(8)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Detector: output goes high the cycle after two consecutive 1s
    always_ff @(posedge CLK or posedge bus.DET_RST) begin
        if (bus.DET_RST) begin
            det_prev <= 1'b0;
            det_q    <= 1'b0;
        end else begin
            det_prev <= bus.DET_IN;
            det_q    <= det_prev & bus.DET_IN;
        end
    end

    assign bus.DET_OUT = stub ? 1'b1 : det_q;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        bus.REQ    = '0;
        bus.BIT_IN = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        int dones;
        stub       = 1'b0;
        RST        = 1'b1;
        bus.REQ    = '0;
        bus.BIT_IN = '0;
        #2;
        n_chk++; if (bus.GNT !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.GNT); else n_pass++;
        n_chk++; if (bus.DET_RST !== 1'b1) $display("FAIL reset_det_rst: got %b want 1", bus.DET_RST); else n_pass++;
        n_chk++; if (bus.DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.DONE); else n_pass++;
        n_chk++; if (bus.HIT_CNT !== 4'd0) $display("FAIL reset_hit_cnt: got %0d want 0", bus.HIT_CNT); else n_pass++;
        n_chk++; if (bus.DONE_ID !== 2'd0) $display("FAIL reset_done_id: got %0d want 0", bus.DONE_ID); else n_pass++;
        n_chk++; if (bus.DET_IN !== 1'b0) $display("FAIL reset_det_in: got %b want 0", bus.DET_IN); else n_pass++;
        tick();
        tick();
        RST = 1'b0;
        tick();
        n_chk++; if (bus.DET_RST !== 1'b0) $display("FAIL idle_det_rst: got %b want 0", bus.DET_RST); else n_pass++;
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.DONE !== 1'b0) dones++;
        end
        n_chk++; if (dones != 0) $display("FAIL idle_no_done: got %0d pulses want 0", dones); else n_pass++;
    endtask

    task automatic test_single();
        int gcnt, dcnt, dk;
        logic [3:0] hit_at_done;
        logic [1:0] id_at_done;
        logic       rst_run;
        stub = 1'b1;
        gcnt = 0; dcnt = 0; dk = -1;
        hit_at_done = 'x; id_at_done = 'x; rst_run = 'x;
        bus.REQ = 4'b0010;
        tick();                      // CLEAR (cycle 1)
        bus.REQ = 4'b0000;
        n_chk++; if (bus.DET_RST !== 1'b1) $display("FAIL single_clear_det_rst: got %b want 1", bus.DET_RST); else n_pass++;
        if (bus.GNT === 4'b0010) gcnt++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.GNT === 4'b0010) gcnt++;
            if (k == 1) rst_run = bus.DET_RST;
            if (bus.DONE === 1'b1) begin
                dcnt++;
                if (dk < 0) begin
                    dk          = k + 1;
                    hit_at_done = bus.HIT_CNT;
                    id_at_done  = bus.DONE_ID;
                end
            end
        end
        n_chk++; if (gcnt != 9) $display("FAIL single_gnt_cycles: got %0d want 9", gcnt); else n_pass++;
        n_chk++; if (rst_run !== 1'b0) $display("FAIL single_run_det_rst: got %b want 0", rst_run); else n_pass++;
        // CLEAR + 8 RUN + FLUSH + REPORT: DONE lands in cycle 11
        n_chk++; if (dk != 11) $display("FAIL single_done_latency: got %0d want 11", dk); else n_pass++;
        n_chk++; if (dcnt != 1) $display("FAIL single_done_pulses: got %0d want 1", dcnt); else n_pass++;
        n_chk++; if (hit_at_done !== 4'd8) $display("FAIL single_hit_cnt: got %0d want 8", hit_at_done); else n_pass++;
        n_chk++; if (id_at_done !== 2'd1) $display("FAIL single_done_id: got %0d want 1", id_at_done); else n_pass++;
        n_chk++; if (bus.HIT_CNT !== 4'd8) $display("FAIL single_hit_held: got %0d want 8", bus.HIT_CNT); else n_pass++;
        stub = 1'b0;
    endtask

    task automatic test_datapath();
        logic [0:7] seq;
        seq  = 8'b1100_1011;         // bits 0..7 = 1,1,0,0,1,0,1,1
        stub = 1'b0;
        bus.REQ = 4'b0100;
        tick();                      // CLEAR
        bus.REQ = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();                  // RUN i
            bus.BIT_IN = seq[i] ? 4'b0100 : 4'b1011;
            #1;
            n_chk++; if (bus.DET_IN !== seq[i]) $display("FAIL dp_det_in[%0d]: got %b want %b", i, bus.DET_IN, seq[i]); else n_pass++;
        end
        tick();                      // FLUSH
        bus.BIT_IN = 4'b1111;
        #1;
        n_chk++; if (bus.DET_IN !== 1'b0) $display("FAIL dp_flush_det_in: got %b want 0", bus.DET_IN); else n_pass++;
        tick();                      // REPORT
        bus.BIT_IN = 4'b0000;
        n_chk++; if (bus.DONE !== 1'b1) $display("FAIL dp_done: got %b want 1", bus.DONE); else n_pass++;
        // "11" detector hits on the bit1 and bit7 responses
        n_chk++; if (bus.HIT_CNT !== 4'd2) $display("FAIL dp_hit_cnt: got %0d want 2", bus.HIT_CNT); else n_pass++;
        n_chk++; if (bus.DONE_ID !== 2'd2) $display("FAIL dp_done_id: got %0d want 2", bus.DONE_ID); else n_pass++;
        tick();                      // IDLE
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [1:0] own;
        do_reset();
        bus.REQ = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            own = 2'(s % 4);
            eg  = 4'b0001 << own;
            tick();                  // CLEAR
            n_chk++; if (bus.GNT !== eg) $display("FAIL rr_gnt[%0d]: got %b want %b", s, bus.GNT, eg); else n_pass++;
            for (int k = 1; k <= 9; k++) tick();
            tick();                  // REPORT
            n_chk++; if (bus.DONE !== 1'b1 || bus.DONE_ID !== own)
                $display("FAIL rr_done_id[%0d]: got done=%b id=%0d want done=1 id=%0d", s, bus.DONE, bus.DONE_ID, own); else n_pass++;
            tick();                  // the single IDLE cycle
            n_chk++; if (bus.GNT !== 4'b0000 || bus.DONE !== 1'b0)
                $display("FAIL rr_idle_gap[%0d]: got gnt=%b done=%b want 0000/0", s, bus.GNT, bus.DONE); else n_pass++;
            if (s == 4) bus.REQ = 4'b0000;
        end
    endtask

    task automatic test_late();
        int bad;
        bad = 0;
        bus.REQ = 4'b1000;           // pointer is 1 -> owner 3
        tick();                      // CLEAR
        n_chk++; if (bus.GNT !== 4'b1000) $display("FAIL late_gnt: got %b want 1000", bus.GNT); else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) bus.REQ = 4'b0001;   // RUN 3: drop REQ[3], raise REQ[0]
            if (k <= 8 && bus.GNT !== 4'b1000) bad++;
            if (k == 10) begin
                n_chk++; if (bus.DONE !== 1'b1 || bus.DONE_ID !== 2'd3)
                    $display("FAIL late_done_id: got done=%b id=%0d want done=1 id=3", bus.DONE, bus.DONE_ID); else n_pass++;
            end
        end
        n_chk++; if (bad != 0) $display("FAIL late_gnt_held: got %0d bad cycles want 0", bad); else n_pass++;
        tick();                      // IDLE
        n_chk++; if (bus.GNT !== 4'b0000) $display("FAIL late_idle_gnt: got %b want 0000", bus.GNT); else n_pass++;
        tick();                      // CLEAR for owner 0
        bus.REQ = 4'b0000;
        n_chk++; if (bus.GNT !== 4'b0001) $display("FAIL late_next_owner: got %b want 0001", bus.GNT); else n_pass++;
        for (int k = 1; k <= 10; k++) tick();
        n_chk++; if (bus.DONE !== 1'b1 || bus.DONE_ID !== 2'd0)
            $display("FAIL late_second_done: got done=%b id=%0d want done=1 id=0", bus.DONE, bus.DONE_ID); else n_pass++;
        tick();                      // IDLE
    endtask

    task automatic test_reset_mid();
        int dones;
        bus.REQ    = 4'b0100;        // pointer is 1 -> owner 2
        bus.BIT_IN = 4'b0100;
        tick();                      // CLEAR
        bus.REQ = 4'b0000;
        for (int k = 1; k <= 5; k++) tick();   // RUN 4
        n_chk++; if (bus.GNT !== 4'b0100) $display("FAIL mid_pre_gnt: got %b want 0100", bus.GNT); else n_pass++;
        RST = 1'b1;
        #1;
        n_chk++; if (bus.GNT !== 4'b0000) $display("FAIL mid_gnt: got %b want 0000", bus.GNT); else n_pass++;
        n_chk++; if (bus.DET_RST !== 1'b1) $display("FAIL mid_det_rst: got %b want 1", bus.DET_RST); else n_pass++;
        n_chk++; if (bus.DET_IN !== 1'b0) $display("FAIL mid_det_in: got %b want 0", bus.DET_IN); else n_pass++;
        tick();
        tick();
        RST        = 1'b0;
        bus.BIT_IN = 4'b0000;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.DONE !== 1'b0) dones++;
        end
        n_chk++; if (dones != 0) $display("FAIL mid_no_done: got %0d pulses want 0", dones); else n_pass++;
        n_chk++; if (bus.HIT_CNT !== 4'd0) $display("FAIL mid_hit_cnt: got %0d want 0", bus.HIT_CNT); else n_pass++;
        bus.REQ = 4'b1111;
        tick();
        n_chk++; if (bus.GNT !== 4'b0001) $display("FAIL mid_rr_restart: got %b want 0001", bus.GNT); else n_pass++;
        bus.REQ = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_datapath();
        test_round_robin();
        test_late();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
